// File: rtl/fw_dnn_capture.sv
// DNN result capture: synchronizes the DUT event toggle and result bits and queues tagged entries in a 16-deep FWFT FIFO.
// Optional macro FW_DNN_CAPTURE_TIMESTAMP_EN adds the bunch-crossing timestamp in bits [31:16].
`timescale 1ns/1ps
module fw_dnn_capture (
  input  logic        fw_pl_clk1,
  input  logic        fw_rst_n,
  input  logic        fw_dev_id_enable,
  input  logic        op_code_w_reset,
  input  logic        capture_enable,
  input  logic        fw_bxclk,
  input  logic        fw_dn_event_toggle,
  input  logic        fw_dnn_output_0,
  input  logic        fw_dnn_output_1,
  input  logic        rd_pop,
  output logic [31:0] rd_data,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic [4:0]  fifo_count,
  output logic        overflow_sticky
);

  logic        r_rst_meta;
  logic        r_rst_n;
  logic [2:0]  r_tgl;
  logic [1:0]  r_dnn0;
  logic [1:0]  r_dnn1;
  logic [31:0] r_mem [16];
  logic [3:0]  r_wr_ptr;
  logic [3:0]  r_rd_ptr;
  logic [4:0]  r_count;
  logic        r_ovf;
  logic [7:0]  r_seq;

  logic        w_event;
  logic        w_accept;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_wr;
  logic        w_drop;
  logic [15:0] w_ts;
  logic [31:0] w_entry;

  // Assertion is immediate; release reaches the core two edges later.
  always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_n    <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_n    <= r_rst_meta;
    end
  end

  always_ff @(posedge fw_pl_clk1 or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_tgl  <= '0;
      r_dnn0 <= '0;
      r_dnn1 <= '0;
    end else begin
      r_tgl  <= {r_tgl[1:0], fw_dn_event_toggle};
      r_dnn0 <= {r_dnn0[0], fw_dnn_output_0};
      r_dnn1 <= {r_dnn1[0], fw_dnn_output_1};
    end
  end

  // Either toggle direction is an event; gating happens only after detection.
  assign w_event  = r_tgl[2] ^ r_tgl[1];
  assign w_accept = w_event & fw_dev_id_enable & capture_enable;

`ifdef FW_DNN_CAPTURE_TIMESTAMP_EN
  logic        r_bx_prev;
  logic [15:0] r_bx_ts;

  always_ff @(posedge fw_pl_clk1 or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_bx_prev <= 1'b0;
      r_bx_ts   <= '0;
    end else begin
      r_bx_prev <= fw_bxclk;
      if (op_code_w_reset)
        r_bx_ts <= '0;
      else if (fw_bxclk && !r_bx_prev)
        r_bx_ts <= r_bx_ts + 16'd1;
    end
  end

  assign w_ts = r_bx_ts;
`else
  logic w_unused_bxclk;
  assign w_unused_bxclk = fw_bxclk;
  assign w_ts = '0;
`endif

  assign w_full  = (r_count == 5'd16);
  assign w_empty = (r_count == 5'd0);
  assign w_pop   = rd_pop & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign w_wr    = w_accept & (~w_full | w_pop);
  assign w_drop  = w_accept & w_full & ~w_pop;
  assign w_entry = {w_ts, r_seq, 6'b0, r_dnn1[1], r_dnn0[1]};

  always_ff @(posedge fw_pl_clk1) begin
    if (w_wr && !op_code_w_reset)
      r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge fw_pl_clk1 or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_seq    <= '0;
    end else if (op_code_w_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_seq    <= '0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + 4'd1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 4'd1;
      r_count <= r_count + {4'b0, w_wr} - {4'b0, w_pop};
      if (w_drop)
        r_ovf <= 1'b1;
      // Dropped events still consume a sequence number so gaps are visible.
      if (w_accept)
        r_seq <= r_seq + 8'd1;
    end
  end

  assign rd_data         = w_empty ? 32'h0 : r_mem[r_rd_ptr];
  assign fifo_empty      = w_empty;
  assign fifo_full       = w_full;
  assign fifo_count      = r_count;
  assign overflow_sticky = r_ovf;

endmodule

// File: tb/tb_fw_dnn_capture.sv
// Self-checking bench for fw_dnn_capture: directed scenarios plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_fw_dnn_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dev_en = 1'b0;
  logic        op_clr = 1'b0;
  logic        cap_en = 1'b0;
  logic        bx = 1'b0;
  logic        tgl = 1'b0;
  logic        dnn0 = 1'b0;
  logic        dnn1 = 1'b0;
  logic        rd_pop = 1'b0;
  logic [31:0] rd_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic [4:0]  fifo_count;
  logic        overflow_sticky;

  int checks = 0;
  int errors = 0;

`ifdef FW_DNN_CAPTURE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  // Reference model: queue of entries, counters kept as plain integers.
  logic [31:0] q[$];
  logic [7:0]  m_seq = 8'h0;
  logic [15:0] m_ts = 16'h0;
  bit          m_sticky = 1'b0;

  always #5 clk = ~clk;

  fw_dnn_capture dut (
    .fw_pl_clk1         (clk),
    .fw_rst_n           (rst_n),
    .fw_dev_id_enable   (dev_en),
    .op_code_w_reset    (op_clr),
    .capture_enable     (cap_en),
    .fw_bxclk           (bx),
    .fw_dn_event_toggle (tgl),
    .fw_dnn_output_0    (dnn0),
    .fw_dnn_output_1    (dnn1),
    .rd_pop             (rd_pop),
    .rd_data            (rd_data),
    .fifo_empty         (fifo_empty),
    .fifo_full          (fifo_full),
    .fifo_count         (fifo_count),
    .overflow_sticky    (overflow_sticky)
  );

  function automatic logic [31:0] mk_entry(input logic [15:0] ts, input logic [7:0] seq,
                                           input logic [1:0] dnn);
    return {(TS_EN ? ts : 16'h0), seq, 6'b0, dnn};
  endfunction

  function automatic logic [31:0] model_head();
    return (q.size() > 0) ? q[0] : 32'h0;
  endfunction

  function automatic void model_clear();
    q.delete();
    m_seq = 8'h0;
    m_ts = 16'h0;
    m_sticky = 1'b0;
  endfunction

  task automatic do_clear();
    @(negedge clk); op_clr = 1'b1;
    @(negedge clk); op_clr = 1'b0;
    model_clear();
  endtask

  task automatic bx_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); bx = 1'b1;
      @(negedge clk); bx = 1'b0;
      m_ts = m_ts + 16'd1;
    end
  endtask

  // Toggle the event line; optional pop/clear land in the cycle the push happens.
  task automatic send_event(input logic [1:0] dnn, input bit with_pop, input bit with_clr);
    bit acc;
    bit pop_ok;
    bit was_full;
    acc = dev_en && cap_en;
    @(negedge clk); tgl = ~tgl; dnn0 = dnn[0]; dnn1 = dnn[1];
    @(negedge clk);
    @(negedge clk); rd_pop = with_pop; op_clr = with_clr;
    @(negedge clk); rd_pop = 1'b0; op_clr = 1'b0;
    if (with_clr) begin
      model_clear();
    end else begin
      pop_ok = with_pop && (q.size() > 0);
      was_full = (q.size() == 16);
      if (pop_ok) void'(q.pop_front());
      if (acc) begin
        if (!was_full || pop_ok) q.push_back(mk_entry(m_ts, m_seq, dnn));
        else m_sticky = 1'b1;
        m_seq = m_seq + 8'd1;
      end
    end
    $display("evt dnn=%b acc=%0d pop=%0d clr=%0d count=%0d", dnn, acc, with_pop, with_clr, fifo_count);
  endtask

  task automatic pop_check(input string name);
    logic [31:0] exp;
    @(negedge clk);
    exp = model_head();
    checks++;
    if (rd_data !== exp) begin
      errors++;
      $display("FAIL %s rd_data got %h exp %h", name, rd_data, exp);
    end
    rd_pop = 1'b1;
    @(negedge clk); rd_pop = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    $display("pop %s data=%h", name, exp);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tgl = 1'b0; bx = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", fifo_empty); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", fifo_full); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    checks++; if (overflow_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b exp 0", overflow_sticky); end
    rst_n = 1'b1; dev_en = 1'b1; cap_en = 1'b1;
    repeat (4) @(negedge clk);
    model_clear();
    $display("reset done");
  endtask

  task automatic test_basic();
    logic [31:0] exp;
    do_clear();
    bx_pulses(5);
    @(negedge clk); tgl = ~tgl; dnn0 = 1'b0; dnn1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL basic_latency_early count got %0d exp 0", fifo_count); end
    @(negedge clk);
    q.push_back(mk_entry(m_ts, m_seq, 2'b10)); m_seq++;
    exp = TS_EN ? 32'h0005_0002 : 32'h0000_0002;
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", fifo_count); end
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL basic_rd_data got %h exp %h", rd_data, exp); end
    pop_check("basic_pop");
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL basic_empty_after_pop got %b exp 1", fifo_empty); end
  endtask

  task automatic test_disabled();
    do_clear();
    cap_en = 1'b0;
    send_event(2'b11, 1'b0, 1'b0);
    send_event(2'b10, 1'b0, 1'b0);
    cap_en = 1'b1; dev_en = 1'b0;
    send_event(2'b11, 1'b0, 1'b0);
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL disabled_count got %0d exp 0", fifo_count); end
    dev_en = 1'b1;
    send_event(2'b01, 1'b0, 1'b0);
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL enabled_count got %0d exp 1", fifo_count); end
    checks++; if (rd_data[15:0] !== 16'h0001) begin errors++; $display("FAIL enabled_low got %h exp 0001", rd_data[15:0]); end
    pop_check("disabled_pop");
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 18; i++) send_event(2'($urandom_range(0, 3)), 1'b0, 1'b0);
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", fifo_count); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", fifo_full); end
    checks++; if (overflow_sticky !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow_sticky); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_data[15:8] !== 8'(i)) begin errors++; $display("FAIL ovf_seq got %h exp %h", rd_data[15:8], 8'(i)); end
      pop_check("ovf_pop");
    end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL ovf_drained got %b exp 1", fifo_empty); end
    checks++; if (overflow_sticky !== 1'b1) begin errors++; $display("FAIL ovf_sticky_hold got %b exp 1", overflow_sticky); end
  endtask

  task automatic test_full_push_pop();
    do_clear();
    for (int i = 0; i < 16; i++) send_event(2'($urandom_range(0, 3)), 1'b0, 1'b0);
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fpp_full got %b exp 1", fifo_full); end
    send_event(2'b11, 1'b1, 1'b0);
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL fpp_count got %0d exp 16", fifo_count); end
    checks++; if (overflow_sticky !== 1'b0) begin errors++; $display("FAIL fpp_sticky got %b exp 0", overflow_sticky); end
    for (int i = 0; i < 15; i++) pop_check("fpp_pop");
    checks++; if (rd_data[15:8] !== 8'h10) begin errors++; $display("FAIL fpp_tail_seq got %h exp 10", rd_data[15:8]); end
    pop_check("fpp_tail");
  endtask

  task automatic test_clear_with_event();
    do_clear();
    for (int i = 0; i < 7; i++) send_event(2'($urandom_range(0, 3)), 1'b0, 1'b0);
    checks++; if (fifo_count !== 5'd7) begin errors++; $display("FAIL clr_pre_count got %0d exp 7", fifo_count); end
    send_event(2'b11, 1'b0, 1'b1);
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL clr_count got %0d exp 0", fifo_count); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL clr_empty got %b exp 1", fifo_empty); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL clr_rd_data got %h exp 0", rd_data); end
    send_event(2'b10, 1'b0, 1'b0);
    checks++; if (rd_data[15:8] !== 8'h00) begin errors++; $display("FAIL clr_next_seq got %h exp 00", rd_data[15:8]); end
    pop_check("clr_pop");
  endtask

  task automatic test_pop_empty();
    do_clear();
    @(negedge clk); rd_pop = 1'b1;
    @(negedge clk); rd_pop = 1'b0;
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL pe_count got %0d exp 0", fifo_count); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL pe_empty got %b exp 1", fifo_empty); end
    send_event(2'b01, 1'b0, 1'b0);
    checks++; if (rd_data !== model_head()) begin errors++; $display("FAIL pe_after got %h exp %h", rd_data, model_head()); end
    pop_check("pe_pop");
  endtask

  task automatic test_random();
    int r;
    do_clear();
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 19);
      if (r < 10) send_event(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'b0);
      else if (r < 15) pop_check("rnd_pop");
      else if (r < 17) bx_pulses($urandom_range(1, 3));
      else if (r < 19) begin cap_en = ($urandom_range(0, 3) != 0); dev_en = ($urandom_range(0, 3) != 0); end
      else do_clear();
      checks++; if (fifo_count !== 5'(q.size())) begin errors++; $display("FAIL rnd_count got %0d exp %0d", fifo_count, q.size()); end
      checks++; if (rd_data !== model_head()) begin errors++; $display("FAIL rnd_rd_data got %h exp %h", rd_data, model_head()); end
      checks++; if (overflow_sticky !== m_sticky) begin errors++; $display("FAIL rnd_sticky got %b exp %b", overflow_sticky, m_sticky); end
      checks++; if (fifo_full !== (q.size() == 16)) begin errors++; $display("FAIL rnd_full got %b exp %b", fifo_full, q.size() == 16); end
    end
    cap_en = 1'b1; dev_en = 1'b1;
  endtask

  task automatic test_async_reset();
    do_clear();
    for (int i = 0; i < 9; i++) send_event(2'($urandom_range(0, 3)), 1'b0, 1'b0);
    checks++; if (fifo_count !== 5'd9) begin errors++; $display("FAIL ar_pre_count got %0d exp 9", fifo_count); end
    @(negedge clk); tgl = ~tgl;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL ar_count got %0d exp 0", fifo_count); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL ar_empty got %b exp 1", fifo_empty); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL ar_full got %b exp 0", fifo_full); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL ar_rd_data got %h exp 0", rd_data); end
    checks++; if (overflow_sticky !== 1'b0) begin errors++; $display("FAIL ar_sticky got %b exp 0", overflow_sticky); end
    tgl = 1'b0; dnn0 = 1'b0; dnn1 = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL ar_inflight got %0d exp 0", fifo_count); end
    send_event(2'b10, 1'b0, 1'b0);
    checks++; if (rd_data !== model_head()) begin errors++; $display("FAIL ar_next got %h exp %h", rd_data, model_head()); end
    pop_check("ar_pop");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_disabled();
    test_overflow();
    test_full_push_pop();
    test_clear_with_event();
    test_pop_empty();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
